// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 frame receiver mapping letter make-codes to 1..26, plus Enter and frame-error pulses.
// Define AUTOREPEAT_SUPPRESS_EN to drop typematic repeats of the last accepted letter.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [4:0] char,
  output logic       char_valid,
  output logic       key_enter,
  output logic       frame_err
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t state;
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic clk_q, fall, dat, par, byte_rdy, ext, brk, repeat_hit, frame_ok;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [TW-1:0] tcnt;
  logic [4:0] code;
  assign fall = clk_q & ~clk_sync[SYNC_STAGES-1];
  assign dat = dat_sync[SYNC_STAGES-1];
  assign frame_ok = dat & (^{sr, par});
  // Synchronizers idle high like the PS/2 bus, so no false edge after reset.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_q <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_q <= clk_sync[SYNC_STAGES-1];
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      sr <= '0;
      bit_cnt <= '0;
      tcnt <= '0;
      par <= 1'b0;
      byte_rdy <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_rdy <= 1'b0;
      frame_err <= 1'b0;
      tcnt <= (fall || state == IDLE) ? '0 : tcnt + 1'b1;
      if (fall)
        case (state)
          IDLE: if (!dat) begin
            bit_cnt <= '0;
            state <= DATA;
          end
          DATA: begin
            sr <= {dat, sr[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par <= dat;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            byte_rdy <= frame_ok;
            frame_err <= ~frame_ok;
          end
        endcase
      else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state <= IDLE;
        frame_err <= 1'b1;
      end
    end
  always_comb
    case (sr)
      8'h1C: code = 5'd1;
      8'h32: code = 5'd2;
      8'h21: code = 5'd3;
      8'h23: code = 5'd4;
      8'h24: code = 5'd5;
      8'h2B: code = 5'd6;
      8'h34: code = 5'd7;
      8'h33: code = 5'd8;
      8'h43: code = 5'd9;
      8'h3B: code = 5'd10;
      8'h42: code = 5'd11;
      8'h4B: code = 5'd12;
      8'h3A: code = 5'd13;
      8'h31: code = 5'd14;
      8'h44: code = 5'd15;
      8'h4D: code = 5'd16;
      8'h15: code = 5'd17;
      8'h2D: code = 5'd18;
      8'h1B: code = 5'd19;
      8'h2C: code = 5'd20;
      8'h3C: code = 5'd21;
      8'h2A: code = 5'd22;
      8'h1D: code = 5'd23;
      8'h22: code = 5'd24;
      8'h35: code = 5'd25;
      8'h1A: code = 5'd26;
      default: code = 5'd0;
    endcase
`ifdef AUTOREPEAT_SUPPRESS_EN
  logic [4:0] last_key;
  assign repeat_hit = code == last_key;
  // A release of the held letter re-arms it; a new make records it.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) last_key <= '0;
    else if (byte_rdy && code != '0) begin
      if (brk) begin
        if (code == last_key) last_key <= '0;
      end else if (!ext) last_key <= code;
    end
`else
  assign repeat_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      char <= '0;
      char_valid <= 1'b0;
      key_enter <= 1'b0;
      ext <= 1'b0;
      brk <= 1'b0;
    end else begin
      char_valid <= 1'b0;
      key_enter <= 1'b0;
      if (frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_rdy) begin
        if (sr == 8'hE0) ext <= 1'b1;
        else if (sr == 8'hF0) brk <= 1'b1;
        else if (brk || ext) begin
          brk <= 1'b0;
          ext <= 1'b0;
        end else if (code != '0) begin
          if (!repeat_hit) begin
            char <= code;
            char_valid <= 1'b1;
          end
        end else key_enter <= sr == 8'h5A;
      end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed PS/2 frames against hand-computed letter codes, pulses and latencies.
module tb_ps2_key_decoder;
  localparam int TO = 100, S = 2, H = 20;
  logic clk = 1'b0, resetn = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic [4:0] char;
  logic char_valid, key_enter, frame_err;
  int checks = 0, failures = 0, cyc = 0, stop_cyc = 0, cv_cyc = 0;
  int n_cv = 0, n_ke = 0, n_fe = 0, n_excl = 0, c0 = 0, k0 = 0, f0 = 0;
  ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(S)) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .char(char), .char_valid(char_valid), .key_enter(key_enter), .frame_err(frame_err)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (resetn) begin
      if (char_valid === 1'b1) begin
        n_cv++;
        cv_cyc = cyc;
      end
      if (key_enter === 1'b1) n_ke++;
      if (frame_err === 1'b1) n_fe++;
      if (int'(char_valid) + int'(key_enter) + int'(frame_err) > 1) n_excl++;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    tick(H);
    ps2_clk = 1'b0;
    stop_cyc = cyc;
    tick(H);
    ps2_clk = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input logic bad_par = 1'b0, input logic bad_stop = 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_dat = 1'b1;
    tick(10);
  endtask
  task automatic mark;
    c0 = n_cv;
    k0 = n_ke;
    f0 = n_fe;
  endtask
  initial begin
    #5 resetn = 1'b0;
    tick(3);
    check("rst_char", char, 0);
    check("rst_cv", char_valid, 0);
    check("rst_ke", key_enter, 0);
    check("rst_fe", frame_err, 0);
    resetn = 1'b1;
    tick(5);
    mark();
    send(8'h1C);
    check("a_char", char, 1);
    check("a_cv", n_cv - c0, 1);
    check("a_latency", cv_cyc - stop_cyc, S + 2);
    mark();
    send(8'h1A);
    send(8'hF0);
    send(8'h1A);
    check("z_cv", n_cv - c0, 1);
    check("z_char", char, 26);
    mark();
    send(8'h24, 1'b1);
    check("par_fe", n_fe - f0, 1);
    check("par_cv", n_cv - c0, 0);
    check("par_char", char, 26);
    send(8'h2D);
    check("r_char", char, 18);
    mark();
    send(8'h1C, 1'b0, 1'b1);
    check("stop_fe", n_fe - f0, 1);
    check("stop_char", char, 18);
    mark();
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    tick(S + TO - H);
    check("to_early", frame_err, 0);
    tick(1);
    check("to_fire", frame_err, 1);
    tick(20);
    check("to_fe_cnt", n_fe - f0, 1);
    send(8'h5A);
    check("to_enter", n_ke - k0, 1);
    mark();
    send(8'hE0);
    send(8'h1C);
    send(8'h5A);
    send(8'h16);
    check("ext_cv", n_cv - c0, 0);
    check("ext_ke", n_ke - k0, 1);
    check("ext_char", char, 18);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    resetn = 1'b0;
    #1;
    check("mid_rst_char", char, 0);
    check("mid_rst_cv", char_valid, 0);
    check("mid_rst_ke", key_enter, 0);
    check("mid_rst_fe", frame_err, 0);
    tick(2);
    resetn = 1'b1;
    tick(5);
    mark();
    send(8'h1C);
    check("post_rst_char", char, 1);
    check("post_rst_cv", n_cv - c0, 1);
    check("post_rst_fe", n_fe - f0, 0);
    mark();
    for (int i = 0; i < 3; i++) send(8'h3A);
    send(8'hF0);
    send(8'h3A);
    send(8'h3A);
`ifdef AUTOREPEAT_SUPPRESS_EN
    check("rep_cv", n_cv - c0, 2);
`else
    check("rep_cv", n_cv - c0, 4);
`endif
    check("rep_char", char, 13);
    check("exclusive", n_excl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
